// File: rtl/matrix_op_sequencer_pkg.sv
// Shared types and field layout for the matrix instruction sequencer.
// The instruction is {opcode[31:29], dst, src1, src2/constant}, packed from the top down.
package matrix_op_sequencer_pkg;

    localparam int INDEX_BIT_DEF = 3;
    localparam int OPC_LSB       = 29;
    localparam int FIELD_MSB     = 28;
    localparam int FIELD_W       = 29;

    typedef enum logic [2:0] {
        OP_NOP  = 3'd0,
        OP_MOV  = 3'd1,
        OP_ADD  = 3'd2,
        OP_SUB  = 3'd3,
        OP_MUL  = 3'd4,
        OP_ADDI = 3'd5,
        OP_MULI = 3'd6,
        OP_HALT = 3'd7
    } opcode_e;

    typedef enum logic [2:0] {
        S_IDLE,
        S_ISSUE,
        S_WAIT,
        S_WRITE,
        S_HALTED,
        S_ERROR
    } state_e;

    // The immediate field takes whatever the opcode and two indices leave over.
    function automatic int const_width(input int index_bit);
        return FIELD_W - 2 * index_bit;
    endfunction

endpackage

// File: rtl/matrix_op_sequencer_if.sv
// Instruction handshake, register-file index bus and ALU control for the sequencer.
// master is the sequencer's view; slave is the instruction source / datapath side.
interface matrix_op_sequencer_if
    import matrix_op_sequencer_pkg::*;
#(
    parameter int INDEX_BIT = INDEX_BIT_DEF
) ();

    localparam int CONST_W = const_width(INDEX_BIT);

    logic                 instr_valid;
    logic                 instr_ready;
    logic [31:0]          instr;
    logic [INDEX_BIT-1:0] mem_read1;
    logic [INDEX_BIT-1:0] mem_read2;
    logic [INDEX_BIT-1:0] mem_write;
    logic                 mem_write_enable;
    logic                 mem_generate_enable;
    logic [CONST_W-1:0]   mem_constant;
    logic                 alu_start;
    logic [2:0]           alu_op;
    logic                 alu_done;

    modport master (
        input  instr_valid, instr, alu_done,
        output instr_ready, mem_read1, mem_read2, mem_write, mem_write_enable,
               mem_generate_enable, mem_constant, alu_start, alu_op
    );

    modport slave (
        output instr_valid, instr, alu_done,
        input  instr_ready, mem_read1, mem_read2, mem_write, mem_write_enable,
               mem_generate_enable, mem_constant, alu_start, alu_op
    );

endinterface

// File: rtl/matrix_op_sequencer_decode.sv
// Combinational field split of a matrix instruction plus its class flags.
module matrix_op_sequencer_decode
    import matrix_op_sequencer_pkg::*;
#(
    parameter  int INDEX_BIT = INDEX_BIT_DEF,
    localparam int CONST_W   = const_width(INDEX_BIT)
) (
    input  logic [31:0]          i_instr,
    output opcode_e              o_opcode,
    output logic [INDEX_BIT-1:0] o_dst,
    output logic [INDEX_BIT-1:0] o_src1,
    output logic [INDEX_BIT-1:0] o_src2,
    output logic [CONST_W-1:0]   o_imm,
    output logic                 o_is_imm,
    output logic                 o_is_nop,
    output logic                 o_is_halt
);

    assign o_opcode  = opcode_e'(i_instr[31:OPC_LSB]);
    assign o_dst     = i_instr[FIELD_MSB -: INDEX_BIT];
    assign o_src1    = i_instr[FIELD_MSB-INDEX_BIT -: INDEX_BIT];
    assign o_imm     = i_instr[CONST_W-1:0];
    // Register and immediate forms share the low bits as the port-2 index.
    assign o_src2    = o_imm[INDEX_BIT-1:0];

    assign o_is_imm  = (o_opcode == OP_ADDI) || (o_opcode == OP_MULI);
    assign o_is_nop  = (o_opcode == OP_NOP);
    assign o_is_halt = (o_opcode == OP_HALT);

endmodule

// File: rtl/matrix_op_sequencer.sv
// Single-issue sequencer: accepts one matrix instruction, starts the ALU, waits for done
// with a timeout, commits with a one-cycle write strobe and tracks halt/error/retire status.
module matrix_op_sequencer
    import matrix_op_sequencer_pkg::*;
#(
    parameter int INDEX_BIT = INDEX_BIT_DEF,
    parameter int TIMEOUT   = 256,
    parameter int CNT_W     = 16
) (
    input  logic                 CLK,
    input  logic                 RST,
    matrix_op_sequencer_if.master bus,
    output logic                 busy,
    output logic                 halted,
    output logic                 error,
    output logic [CNT_W-1:0]     retire_count
);

    localparam int CONST_W = const_width(INDEX_BIT);
    localparam int TMR_W   = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

    opcode_e              w_opcode;
    logic [INDEX_BIT-1:0] w_dst, w_src1, w_src2;
    logic [CONST_W-1:0]   w_imm;
    logic                 w_is_imm, w_is_nop, w_is_halt;
    logic                 w_accept, w_retire_now, w_in_flight;

    state_e               r_state, w_next;
    logic [TMR_W-1:0]     r_timer;
    logic [CNT_W-1:0]     r_count;
    logic [2:0]           r_op;
    logic [INDEX_BIT-1:0] r_dst, r_src1, r_src2;
    logic [CONST_W-1:0]   r_imm;
    logic                 r_gen;

    matrix_op_sequencer_decode #(.INDEX_BIT(INDEX_BIT)) u_decode (
        .i_instr   (bus.instr),
        .o_opcode  (w_opcode),
        .o_dst     (w_dst),
        .o_src1    (w_src1),
        .o_src2    (w_src2),
        .o_imm     (w_imm),
        .o_is_imm  (w_is_imm),
        .o_is_nop  (w_is_nop),
        .o_is_halt (w_is_halt)
    );

    assign w_accept     = bus.instr_valid && (r_state == S_IDLE);
    assign w_retire_now = (w_accept && (w_is_nop || w_is_halt)) || (r_state == S_WRITE);
    assign w_in_flight  = (r_state == S_ISSUE) || (r_state == S_WAIT) || (r_state == S_WRITE);

    // NOTE: every output of a combinational block gets a default first so no latch is inferred.
    always_comb begin
        w_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) begin
                    if (w_is_halt)     w_next = S_HALTED;
                    else if (!w_is_nop) w_next = S_ISSUE;
                end
            end
            S_ISSUE: w_next = S_WAIT;
            S_WAIT: begin
                if (bus.alu_done)                              w_next = S_WRITE;
                else if (r_timer == TMR_W'(TIMEOUT - 1))       w_next = S_ERROR;
            end
            S_WRITE:  w_next = S_IDLE;
            S_HALTED: w_next = S_HALTED;
            S_ERROR:  w_next = S_ERROR;
            default:  w_next = S_IDLE;
        endcase
    end

    // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) r_state <= S_IDLE;
        else     r_state <= w_next;
    end

    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_timer <= '0;
            r_count <= '0;
        end else begin
            if (r_state == S_ISSUE)     r_timer <= '0;
            else if (r_state == S_WAIT) r_timer <= r_timer + 1'b1;
            if (w_retire_now)           r_count <= r_count + 1'b1;
        end
    end

    // NOTE: the instruction latch is reset too, so indices and constant read 0 after reset.
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            r_op   <= '0;
            r_dst  <= '0;
            r_src1 <= '0;
            r_src2 <= '0;
            r_imm  <= '0;
            r_gen  <= 1'b0;
        end else if (w_accept) begin
            r_op <= w_opcode;
            // NOP/HALT leave the datapath fields alone so the index bus holds its last value.
            if (!w_is_nop && !w_is_halt) begin
                r_dst  <= w_dst;
                r_src1 <= w_src1;
                r_src2 <= w_src2;
                r_imm  <= w_imm;
                r_gen  <= w_is_imm;
            end
        end
    end

    assign bus.instr_ready         = (r_state == S_IDLE) && !RST;
    assign bus.mem_read1           = r_src1;
    assign bus.mem_read2           = r_src2;
    assign bus.mem_write           = r_dst;
    assign bus.mem_constant        = r_imm;
    assign bus.mem_generate_enable = r_gen && w_in_flight;
    assign bus.mem_write_enable    = (r_state == S_WRITE);
    assign bus.alu_start           = (r_state == S_ISSUE);
    assign bus.alu_op              = r_op;

    assign busy         = (r_state != S_IDLE) && (r_state != S_HALTED);
    assign halted       = (r_state == S_HALTED);
    assign error        = (r_state == S_ERROR);
    assign retire_count = r_count;

endmodule

// File: tb/tb_matrix_op_sequencer.sv
// Directed bench for matrix_op_sequencer: issue, immediate, back-to-back/halt, timeout,
// mid-operation reset and retire-counter wrap, with hand-computed expectations.
module tb_matrix_op_sequencer;
    import matrix_op_sequencer_pkg::*;

    localparam int IB = 3;
    localparam int TO = 8;
    localparam int CW = 4;

    logic          CLK = 1'b0;
    logic          RST = 1'b1;
    logic          busy, halted, error;
    logic [CW-1:0] retire_count;

    int n_checks = 0;
    int n_fail   = 0;
    int we_cnt   = 0;
    int start_cnt = 0;
    int we_base, start_base;

    always #5 CLK = ~CLK;

    matrix_op_sequencer_if #(.INDEX_BIT(IB)) mif ();

    matrix_op_sequencer #(.INDEX_BIT(IB), .TIMEOUT(TO), .CNT_W(CW)) dut (
        .CLK          (CLK),
        .RST          (RST),
        .bus          (mif.master),
        .busy         (busy),
        .halted       (halted),
        .error        (error),
        .retire_count (retire_count)
    );

    always @(negedge CLK) begin
        if (mif.mem_write_enable) we_cnt++;
        if (mif.alu_start)        start_cnt++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    function automatic logic [31:0] mk(input logic [2:0] op, input int dst, input int src1, input int imm);
        return {op, 3'(dst), 3'(src1), 23'(imm)};
    endfunction

    task automatic do_reset();
        RST = 1'b1;
        mif.instr_valid = 1'b0;
        mif.instr       = '0;
        mif.alu_done    = 1'b0;
        repeat (2) @(posedge CLK);
        #1 RST = 1'b0;
        #1;
    endtask

    // Present an instruction, wait (bounded) for ready, let one edge accept it.
    task automatic issue(input logic [31:0] ins);
        int waited = 0;
        mif.instr       = ins;
        mif.instr_valid = 1'b1;
        while (!mif.instr_ready && waited < 20) begin
            tick();
            waited++;
        end
        if (!mif.instr_ready) check("issue_ready", {31'b0, mif.instr_ready}, 32'd1);
        tick();
        mif.instr_valid = 1'b0;
    endtask

    // From the ISSUE cycle, raise alu_done n cycles after alu_start; returns in the WRITE cycle.
    task automatic respond(input int n);
        repeat (n) tick();
        mif.alu_done = 1'b1;
        tick();
        mif.alu_done = 1'b0;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        mif.instr_valid = 1'b0;
        mif.instr       = '0;
        mif.alu_done    = 1'b0;

        // Reset state
        #2;
        check("rst_ready",  {31'b0, mif.instr_ready}, 32'd0);
        check("rst_start",  {31'b0, mif.alu_start}, 32'd0);
        check("rst_busy",   {31'b0, busy}, 32'd0);
        check("rst_count",  {28'b0, retire_count}, 32'd0);
        do_reset();
        check("idle_ready", {31'b0, mif.instr_ready}, 32'd1);

        // 1: ADD dst2, src0, src1, done 3 cycles after start
        we_base = we_cnt; start_base = start_cnt;
        issue(mk(OP_ADD, 2, 0, 1));
        check("t1_start",  {31'b0, mif.alu_start}, 32'd1);
        check("t1_read1",  {29'b0, mif.mem_read1}, 32'd0);
        check("t1_read2",  {29'b0, mif.mem_read2}, 32'd1);
        check("t1_write",  {29'b0, mif.mem_write}, 32'd2);
        check("t1_op",     {29'b0, mif.alu_op}, 32'd2);
        check("t1_gen",    {31'b0, mif.mem_generate_enable}, 32'd0);
        check("t1_busy",   {31'b0, busy}, 32'd1);
        respond(3);
        check("t1_we",     {31'b0, mif.mem_write_enable}, 32'd1);
        tick();
        check("t1_we_n",   we_cnt - we_base, 32'd1);
        check("t1_st_n",   start_cnt - start_base, 32'd1);
        check("t1_count",  {28'b0, retire_count}, 32'd1);
        check("t1_ready",  {31'b0, mif.instr_ready}, 32'd1);

        // 2: ADDI dst1, src1, imm 5
        issue(mk(OP_ADDI, 1, 1, 5));
        check("t2_gen_is", {31'b0, mif.mem_generate_enable}, 32'd1);
        check("t2_const",  {9'b0, mif.mem_constant}, 32'd5);
        check("t2_read2",  {29'b0, mif.mem_read2}, 32'd5);
        check("t2_write",  {29'b0, mif.mem_write}, 32'd1);
        tick();
        check("t2_gen_wt", {31'b0, mif.mem_generate_enable}, 32'd1);
        mif.alu_done = 1'b1;
        tick();
        mif.alu_done = 1'b0;
        check("t2_gen_wr", {31'b0, mif.mem_generate_enable}, 32'd1);
        check("t2_we",     {31'b0, mif.mem_write_enable}, 32'd1);
        tick();
        check("t2_gen_id", {31'b0, mif.mem_generate_enable}, 32'd0);
        check("t2_const_h", {9'b0, mif.mem_constant}, 32'd5);
        check("t2_count",  {28'b0, retire_count}, 32'd2);

        // 3: back-to-back NOP, MUL, HALT, then a refused instruction
        do_reset();
        we_base = we_cnt; start_base = start_cnt;
        issue(mk(OP_NOP, 0, 0, 0));
        check("t3_nop_cnt", {28'b0, retire_count}, 32'd1);
        check("t3_nop_rdy", {31'b0, mif.instr_ready}, 32'd1);
        issue(mk(OP_MUL, 3, 4, 6));
        check("t3_nop_nost", start_cnt - start_base, 32'd0);
        check("t3_mul_wr", {29'b0, mif.mem_write}, 32'd3);
        respond(2);
        tick();
        check("t3_mul_we", we_cnt - we_base, 32'd1);
        issue(mk(OP_HALT, 0, 0, 0));
        check("t3_halted", {31'b0, halted}, 32'd1);
        check("t3_count",  {28'b0, retire_count}, 32'd3);
        check("t3_busy",   {31'b0, busy}, 32'd0);
        mif.instr       = mk(OP_ADD, 1, 2, 3);
        mif.instr_valid = 1'b1;
        repeat (4) tick();
        mif.instr_valid = 1'b0;
        check("t3_refuse_rdy", {31'b0, mif.instr_ready}, 32'd0);
        check("t3_refuse_st",  start_cnt - start_base, 32'd1);
        check("t3_refuse_cnt", {28'b0, retire_count}, 32'd3);
        check("t3_err",    {31'b0, error}, 32'd0);

        // 4: ALU never answers, timeout after 8 WAIT cycles
        do_reset();
        we_base = we_cnt;
        issue(mk(OP_SUB, 5, 6, 7));
        tick();
        for (int k = 1; k <= 8; k++) begin
            tick();
            if (k == 7) check("t4_err_early", {31'b0, error}, 32'd0);
        end
        check("t4_err",    {31'b0, error}, 32'd1);
        check("t4_halt",   {31'b0, halted}, 32'd0);
        check("t4_ready",  {31'b0, mif.instr_ready}, 32'd0);
        mif.alu_done = 1'b1;
        repeat (2) tick();
        mif.alu_done = 1'b0;
        check("t4_sticky", {31'b0, error}, 32'd1);
        check("t4_no_we",  we_cnt - we_base, 32'd0);
        check("t4_count",  {28'b0, retire_count}, 32'd0);

        // 5: reset during WAIT aborts the instruction
        do_reset();
        we_base = we_cnt;
        issue(mk(OP_ADD, 3, 1, 2));
        repeat (2) tick();
        RST = 1'b1;
        #1;
        check("t5_ready",  {31'b0, mif.instr_ready}, 32'd0);
        check("t5_start",  {31'b0, mif.alu_start}, 32'd0);
        check("t5_we",     {31'b0, mif.mem_write_enable}, 32'd0);
        check("t5_busy",   {31'b0, busy}, 32'd0);
        check("t5_write",  {29'b0, mif.mem_write}, 32'd0);
        check("t5_read1",  {29'b0, mif.mem_read1}, 32'd0);
        check("t5_const",  {9'b0, mif.mem_constant}, 32'd0);
        check("t5_op",     {29'b0, mif.alu_op}, 32'd0);
        check("t5_count",  {28'b0, retire_count}, 32'd0);
        do_reset();
        check("t5_no_we",  we_cnt - we_base, 32'd0);
        issue(mk(OP_ADD, 4, 5, 6));
        check("t5_rd1",    {29'b0, mif.mem_read1}, 32'd5);
        check("t5_rd2",    {29'b0, mif.mem_read2}, 32'd6);
        respond(1);
        check("t5_wr",     {29'b0, mif.mem_write}, 32'd4);
        check("t5_we2",    {31'b0, mif.mem_write_enable}, 32'd1);
        tick();
        check("t5_count2", {28'b0, retire_count}, 32'd1);

        // 6: retire counter wraps (CNT_W=4)
        do_reset();
        for (int i = 0; i < 15; i++) issue(mk(OP_NOP, 0, 0, 0));
        check("t6_full",   {28'b0, retire_count}, 32'd15);
        issue(mk(OP_ADD, 2, 0, 1));
        respond(1);
        tick();
        check("t6_wrap",   {28'b0, retire_count}, 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
